// File: rtl/bram_pkg.sv
// Shared types for the BRAM responder: the host-ownership FSM states and the
// helper that sizes the fill/dump pointer.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL       = 2'd1,
    DUMP       = 2'd2,
    DUMP_DRAIN = 2'd3
  } state_t;

  // The pointer must be able to hold DEPTH itself, so it is clog2(DEPTH+1) wide.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_skid_buffer.sv
// Two-entry ready/valid buffer carrying a data word plus a last flag.
// Entry 0 is always the head. The producer must not push into a full buffer unless it pops in the same cycle.
module bram_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);

  // Handshake: a word transfers on any clock edge where out_valid && out_ready.
  logic [DATA_WIDTH:0] ent0;
  logic [DATA_WIDTH:0] ent1;
  logic                pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = ent0[DATA_WIDTH-1:0];
  assign out_last  = ent0[DATA_WIDTH];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= {push_last, push_data};
          else               ent1 <= {push_last, push_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= {push_last, push_data};
          end else begin
            ent0 <= ent1;
            ent1 <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_responder.sv
// Dual-port BRAM model for kernel benches, with a host stream port to preload
// (FILL) and dump (DUMP) the array, plus sticky protocol-error flags.
module bram_responder
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic                  ce1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] din1,
  input  logic                  fill_start,
  input  logic                  dump_start,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_rd_valid,
  input  logic                  host_rd_ready,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  host_rd_last,
  output logic                  busy,
  output logic                  oob_err,
  output logic                  own_err,
  output state_t                fsm_state
);

  localparam int                PW       = ptr_width(DEPTH);
  localparam logic [PW-1:0]     LAST_PTR = PW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_nxt;
  logic [PW-1:0]         ptr, ptr_nxt;
  logic [ADDR_WIDTH-1:0] ptr_addr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic k_en0, k_en1, in_rng0, in_rng1;
  logic k_wr0, k_wr1, k_rd0, k_rd1, k_oob0, k_oob1;
  logic fill_wr, rd_issue, pop;
  logic rd_pend, rd_pend_last;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            buf_count;
  logic [2:0]            occ;

  assign ptr_addr      = ADDR_WIDTH'(ptr);
  assign busy          = (state != IDLE);
  assign host_wr_ready = (state == FILL);
  assign fsm_state     = state;

  // Kernel ports are only honoured while the host does not own the array.
  assign k_en0   = ce0 && !busy;
  assign k_en1   = ce1 && !busy;
  assign in_rng0 = {1'b0, address0} < DEPTH_A;
  assign in_rng1 = {1'b0, address1} < DEPTH_A;
  assign k_wr0   = k_en0 && we0 && in_rng0;
  assign k_wr1   = k_en1 && we1 && in_rng1;
  assign k_rd0   = k_en0 && !we0 && in_rng0;
  assign k_rd1   = k_en1 && !we1 && in_rng1;
  assign k_oob0  = k_en0 && !in_rng0;
  assign k_oob1  = k_en1 && !in_rng1;

  assign fill_wr = (state == FILL) && host_wr_valid;
  assign pop     = host_rd_valid && host_rd_ready;

  // Occupancy the in-flight read will see when it lands; issue only if a slot is left.
  assign occ      = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue = (state == DUMP) && (occ <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = FILL;
          ptr_nxt   = '0;
        end else if (dump_start) begin
          state_nxt = DUMP;
          ptr_nxt   = '0;
        end
      end
      FILL: begin
        if (fill_wr) begin
          ptr_nxt = ptr + PW'(1);
          if (ptr == LAST_PTR) state_nxt = IDLE;
        end
      end
      DUMP: begin
        if (rd_issue) begin
          ptr_nxt = ptr + PW'(1);
          if (ptr == LAST_PTR) state_nxt = DUMP_DRAIN;
        end
      end
      DUMP_DRAIN: begin
        if (buf_count == 2'd0 && !rd_pend) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Array is never reset. Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (fill_wr) mem[ptr_addr] <= host_wr_data;
    if (k_wr0)   mem[address0] <= dout0;
    if (k_wr1)   mem[address1] <= dout1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din0    <= '0;
      din1    <= '0;
      oob_err <= 1'b0;
      own_err <= 1'b0;
    end else begin
      if (k_rd0)       din0 <= mem[address0];
      else if (k_oob0) din0 <= '0;
      if (k_rd1)       din1 <= mem[address1];
      else if (k_oob1) din1 <= '0;
      if (k_oob0 || k_oob1)        oob_err <= 1'b1;
      if (busy && (ce0 || ce1))    own_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rd_word      <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_word      <= mem[ptr_addr];
        rd_pend_last <= (ptr == LAST_PTR);
      end
    end
  end

  bram_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend),
    .push_data(rd_word),
    .push_last(rd_pend_last),
    .out_valid(host_rd_valid),
    .out_ready(host_rd_ready),
    .out_data (host_rd_data),
    .out_last (host_rd_last),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_bram_responder.sv
// Directed bench for bram_responder: a DEPTH=16 instance for fill/dump/kernel
// behaviour and a DEPTH=12 instance for out-of-range accesses.
module tb_bram_responder;
  import bram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       ce0 = 0, we0 = 0, ce1 = 0, we1 = 0;
  logic [3:0] address0 = 0, address1 = 0;
  logic [7:0] dout0 = 0, dout1 = 0, din0, din1;
  logic       fill_start = 0, dump_start = 0, host_wr_valid = 0, host_rd_ready = 0;
  logic [7:0] host_wr_data = 0, host_rd_data;
  logic       host_wr_ready, host_rd_valid, host_rd_last, busy, oob_err, own_err;
  state_t     fsm_state;

  // DEPTH=12 instance; host side tied off
  logic       s_ce0 = 0, s_we0 = 0, s_ce1 = 0, s_we1 = 0;
  logic [3:0] s_address0 = 0, s_address1 = 0;
  logic [7:0] s_dout0 = 0, s_dout1 = 0, s_din0, s_din1;
  logic       s_fill_start = 0, s_dump_start = 0, s_host_wr_valid = 0, s_host_rd_ready = 0;
  logic [7:0] s_host_wr_data = 0, s_host_rd_data;
  logic       s_host_wr_ready, s_host_rd_valid, s_host_rd_last, s_busy, s_oob_err, s_own_err;
  state_t     s_fsm_state;

  bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0), .din0(din0),
    .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1), .din1(din1),
    .fill_start(fill_start), .dump_start(dump_start),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
    .host_rd_last(host_rd_last), .busy(busy), .oob_err(oob_err), .own_err(own_err),
    .fsm_state(fsm_state)
  );

  bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .ce0(s_ce0), .we0(s_we0), .address0(s_address0), .dout0(s_dout0), .din0(s_din0),
    .ce1(s_ce1), .we1(s_we1), .address1(s_address1), .dout1(s_dout1), .din1(s_din1),
    .fill_start(s_fill_start), .dump_start(s_dump_start),
    .host_wr_valid(s_host_wr_valid), .host_wr_ready(s_host_wr_ready), .host_wr_data(s_host_wr_data),
    .host_rd_valid(s_host_rd_valid), .host_rd_ready(s_host_rd_ready), .host_rd_data(s_host_rd_data),
    .host_rd_last(s_host_rd_last), .busy(s_busy), .oob_err(s_oob_err), .own_err(s_own_err),
    .fsm_state(s_fsm_state)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       ce0, we0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       ce1, we1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [7:0] e0, e1;
  } kvec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic kdrive(input logic c0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic c1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    ce0 = c0; we0 = w0; address0 = a0; dout0 = d0;
    ce1 = c1; we1 = w1; address1 = a1; dout1 = d1;
  endtask

  task automatic sdrive(input logic c0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic c1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    s_ce0 = c0; s_we0 = w0; s_address0 = a0; s_dout0 = d0;
    s_ce1 = c1; s_we1 = w1; s_address1 = a1; s_dout1 = d1;
    tick();
    s_ce0 = 0; s_ce1 = 0; s_we0 = 0; s_we1 = 0;
  endtask

  // Streams words 0x00..0x0F into an already-started FILL, with random idle gaps.
  task automatic fill_words();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        host_wr_valid = 0;
        tick();
      end
      check("fill_ready", host_wr_ready, 1);
      host_wr_valid = 1;
      host_wr_data  = 8'(i);
      tick();
    end
    host_wr_valid = 0;
    check("fill_done_state", fsm_state, IDLE);
    check("fill_done_ready", host_wr_ready, 0);
  endtask

  task automatic fill_mem();
    fill_start = 1;
    tick();
    fill_start = 0;
    fill_words();
  endtask

  kvec_t vecs[7];
  int    got;
  logic [7:0] w;

  initial begin
    // ce0 we0 a0 d0 | ce1 we1 a1 d1 | din0 din1 expected after the edge
    vecs[0] = '{1, 0, 4'd5, 8'h00, 1, 1, 4'd5,  8'hAA, 8'h05, 8'h11};
    vecs[1] = '{1, 0, 4'd5, 8'h00, 1, 0, 4'd6,  8'h00, 8'hAA, 8'h06};
    vecs[2] = '{1, 1, 4'd3, 8'h11, 1, 1, 4'd3,  8'h22, 8'hAA, 8'h06};
    vecs[3] = '{0, 0, 4'd0, 8'h00, 1, 0, 4'd3,  8'h00, 8'hAA, 8'h22};
    vecs[4] = '{1, 1, 4'd7, 8'h77, 1, 0, 4'd7,  8'h00, 8'hAA, 8'h07};
    vecs[5] = '{1, 0, 4'd7, 8'h00, 0, 0, 4'd0,  8'h00, 8'h77, 8'h07};
    vecs[6] = '{1, 0, 4'd0, 8'h00, 1, 0, 4'd15, 8'h00, 8'h00, 8'h0F};

    // Reset values
    repeat (2) tick();
    check("rst_din0", din0, 0);
    check("rst_din1", din1, 0);
    check("rst_rd_data", host_rd_data, 0);
    check("rst_rd_valid", host_rd_valid, 0);
    check("rst_rd_last", host_rd_last, 0);
    check("rst_wr_ready", host_wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {oob_err, own_err}, 0);
    check("rst_state", fsm_state, IDLE);
    rst_n = 1;
    tick();

    // Reset in the middle of FILL; array contents survive
    fill_start = 1; tick(); fill_start = 0;
    check("midfill_busy", busy, 1);
    host_wr_valid = 1; host_wr_data = 8'h11; tick();
    host_wr_data = 8'h22; tick();
    host_wr_valid = 0;
    rst_n = 0;
    #1;
    check("midfill_rst_state", fsm_state, IDLE);
    check("midfill_rst_ready", host_wr_ready, 0);
    tick();
    rst_n = 1;
    tick();
    kdrive(1, 0, 4'd1, 0, 1, 0, 4'd0, 0);
    tick();
    kdrive(0, 0, 0, 0, 0, 0, 0, 0);
    check("midfill_read1", din0, 8'h22);
    check("midfill_read0", din1, 8'h11);

    // Full fill, then table of kernel accesses
    fill_mem();
    for (int i = 0; i < 7; i++) begin
      kdrive(vecs[i].ce0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
             vecs[i].ce1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      tick();
      check($sformatf("vec%0d_din0", i), din0, vecs[i].e0);
      check($sformatf("vec%0d_din1", i), din1, vecs[i].e1);
    end
    kdrive(0, 0, 0, 0, 0, 0, 0, 0);
    check("kernel_errs", {oob_err, own_err}, 0);

    // Dump with 1,0,0 backpressure; kernel write and a fill_start injected mid-dump
    fill_mem();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    dump_start = 1; tick(); dump_start = 0;
    check("dump_state", fsm_state, DUMP);
    got = 0;
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      host_rd_ready = (cyc % 3 == 0);
      if (cyc == 5) kdrive(1, 1, 4'd15, 8'h99, 0, 0, 0, 0);
      if (cyc == 8) fill_start = 1;
      if (host_rd_valid && host_rd_ready) begin
        w = exp_q.pop_front();
        check($sformatf("dump_word%0d", got), host_rd_data, w);
        check($sformatf("dump_last%0d", got), host_rd_last, (w == 8'h0F));
        got++;
      end
      tick();
      kdrive(0, 0, 0, 0, 0, 0, 0, 0);
      fill_start = 0;
    end
    host_rd_ready = 0;
    check("dump_count", got, 16);
    tick();
    check("dump_end_state", fsm_state, IDLE);
    check("dump_end_valid", host_rd_valid, 0);
    check("own_err_set", own_err, 1);
    check("own_din0_hold", din0, 8'h00);
    check("own_no_oob", oob_err, 0);

    // Simultaneous start pulses: fill wins
    fill_start = 1; dump_start = 1; tick();
    fill_start = 0; dump_start = 0;
    check("both_start_state", fsm_state, FILL);
    fill_words();

    // Out-of-range accesses on the DEPTH=12 instance
    sdrive(1, 1, 4'd4, 8'h44, 0, 0, 0, 0);
    sdrive(1, 0, 4'd4, 0, 0, 0, 0, 0);
    check("s_read4", s_din0, 8'h44);
    sdrive(1, 1, 4'd11, 8'hBB, 0, 0, 0, 0);
    sdrive(0, 0, 0, 0, 1, 0, 4'd11, 0);
    check("s_read11", s_din1, 8'hBB);
    check("s_oob_clear", s_oob_err, 0);
    sdrive(1, 0, 4'd14, 0, 1, 1, 4'd13, 8'hEE);
    check("s_oob_din0", s_din0, 0);
    check("s_oob_din1", s_din1, 0);
    check("s_oob_set", s_oob_err, 1);
    sdrive(0, 0, 0, 0, 0, 0, 0, 0);
    check("s_oob_sticky", s_oob_err, 1);
    sdrive(1, 0, 4'd4, 0, 1, 0, 4'd11, 0);
    check("s_reread4", s_din0, 8'h44);
    check("s_reread11", s_din1, 8'hBB);
    check("s_own_err", s_own_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Dual-port BRAM model: the memory end of the ce/we/address/dout/din interface driven by the mem_to_bram converters.
- Instantiated once per memory argument in kernel simulation benches and FPGA emulation tops.
- Adds a host-side ready/valid stream port to preload contents before the kernel runs and to dump contents after it finishes.
- Flags protocol errors: out-of-range kernel accesses and kernel access while the host owns the memory.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width in bits.
- DEPTH, 16, number of valid words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ce0  in  1  port 0 enable.
- we0  in  1  port 0 write enable.
- address0  in  ADDR_WIDTH  port 0 address.
- dout0  in  DATA_WIDTH  port 0 write data (kernel to memory).
- din0  out  DATA_WIDTH  port 0 read data (memory to kernel).
- ce1, we1, address1, dout1, din1  same as port 0, for port 1.
- fill_start  in  1  pulse in IDLE: enter FILL.
- dump_start  in  1  pulse in IDLE: enter DUMP.
- host_wr_valid  in  1  fill stream valid.
- host_wr_ready  out  1  fill stream ready.
- host_wr_data  in  DATA_WIDTH  fill word.
- host_rd_valid  out  1  dump stream valid.
- host_rd_ready  in  1  dump stream ready.
- host_rd_data  out  DATA_WIDTH  dump word.
- host_rd_last  out  1  high with the final dump word.
- busy  out  1  high in FILL or DUMP.
- oob_err  out  1  sticky: kernel access to address >= DEPTH.
- own_err  out  1  sticky: kernel ce asserted while busy.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - State goes to IDLE; counters cleared.
  - din0, din1, host_rd_data = 0.
  - host_wr_ready, host_rd_valid, host_rd_last, busy, oob_err, own_err = 0.
  - Memory array is NOT reset; contents are retained.
- Kernel ports in IDLE:
  - Write: ce&we with address < DEPTH writes mem[address] at the clock edge.
  - Read: ce&!we registers mem[address] into din on the next edge (latency 1). din holds its value when ce=0.
  - Read-during-write to the same address on either port is read-first: din returns the old data.
  - Both ports writing the same address in one cycle: port 1 wins.
  - Any access with address >= DEPTH: write dropped, din loads 0, oob_err set.
- FSM states: IDLE, FILL, DUMP, DUMP_DRAIN.
  - IDLE -> FILL on fill_start. Pointer=0, host_wr_ready=1.
  - IDLE -> DUMP on dump_start. Pointer=0.
  - fill_start and dump_start together: fill_start wins.
  - FILL: each host_wr_valid&ready writes mem[ptr] and increments ptr. After the write at ptr=DEPTH-1, next state is IDLE and host_wr_ready drops in the same edge.
  - DUMP: issues an internal read of mem[ptr] (1-cycle latency) into a 2-entry skid buffer.
    - The read is issued only when the buffer has space for the in-flight word.
    - host_rd_data comes from the buffer head; host_rd_valid=1 while the buffer is non-empty.
    - host_rd_ready may be held low arbitrarily; no word is lost or duplicated, and words are emitted in address order 0..DEPTH-1.
  - After the last read is issued, go to DUMP_DRAIN.
  - DUMP_DRAIN: wait for the buffer to empty, then go to IDLE.
  - host_rd_last=1 with word DEPTH-1.
  - start pulses outside IDLE are ignored.
- busy=1 in FILL, DUMP, DUMP_DRAIN.
  - While busy, kernel ce0/ce1 are ignored: no write, din unchanged.
  - Any kernel ce while busy sets own_err.
- Error flags clear only on reset.
- Pointer width is clog2(DEPTH+1); no wrap-around beyond DEPTH.

Decomposition:
- Shared package bram_pkg:
  - state enum: IDLE, FILL, DUMP, DUMP_DRAIN.
  - localparam function for pointer width.
- Sub-module bram_skid_buffer (2-entry ready/valid buffer with last flag) for the dump path.
- Memory array and port logic stay in the top module.

Test Plan:
- Reset mid-FILL:
  - Stimulus: fill words 0x11, 0x22, then pulse rst_n low.
  - Response: state IDLE, host_wr_ready=0; a later kernel read of address 1 returns 0x22 one cycle after ce0.
- Fill then kernel read/write:
  - Stimulus: fill 0x00..0x0F; port0 read address 5; port1 write 0xAA to address 5 in the same cycle.
  - Response: din0=0x05 (read-first); a next read returns 0xAA.
- Dump with backpressure:
  - Stimulus: memory holds 0x00..0x0F; host_rd_ready toggles 1,0,0,1,...
  - Response: exactly 16 words 0x00..0x0F in order; host_rd_last only with 0x0F; then IDLE.
- Dual write collision:
  - Stimulus: both ports write address 3, port0 0x11 and port1 0x22.
  - Response: mem[3]=0x22.
- Out-of-range access:
  - Stimulus: DEPTH=12, write address 13, read address 14.
  - Response: no array change; din=0; oob_err=1 and sticky.
- Ownership violation:
  - Stimulus: ce0=1 during DUMP.
  - Response: own_err=1; dump stream is unaffected; din0 holds its previous value.
